// File: rtl/c7b_biu_pkg.sv
// Shared types and defaults for the c7bbiu memory-port arbiter.
package c7b_biu_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

  localparam int unsigned StarveMaxDefault = 4;
  localparam int unsigned StarveCntW       = 3;

endpackage

// File: rtl/c7bbiu_starve_cnt.sv
// Saturating count of consecutive LSU grants taken while fetch was waiting.
module c7bbiu_starve_cnt
  import c7b_biu_pkg::*;
#(
  parameter int unsigned StarveMax = StarveMaxDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [StarveCntW-1:0] MaxVal = StarveCntW'(StarveMax);

  logic [StarveCntW-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == MaxVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/c7bbiu_arb.sv
// IFU/LSU arbiter for the single 64-bit memory port: one outstanding
// transaction, response routing, flush drop and anti-starvation for fetch.
module c7bbiu_arb
  import c7b_biu_pkg::*;
#(
  parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_biu_req,
  input  logic [31:0] ifu_biu_addr,
  output logic        biu_ifu_ack,
  output logic        biu_ifu_data_vld,
  output logic [63:0] biu_ifu_data,
  input  logic        ifu_biu_cancel,
  input  logic        lsu_biu_req,
  input  logic        lsu_biu_wr,
  input  logic [31:0] lsu_biu_addr,
  input  logic [63:0] lsu_biu_wdata,
  input  logic [7:0]  lsu_biu_wstrb,
  output logic        biu_lsu_ack,
  output logic        biu_lsu_data_vld,
  output logic [63:0] biu_lsu_data,
  output logic        biu_mem_req,
  output logic        biu_mem_wr,
  output logic [31:0] biu_mem_addr,
  output logic [63:0] biu_mem_wdata,
  output logic [7:0]  biu_mem_wstrb,
  input  logic        mem_biu_ack,
  input  logic        mem_biu_rvalid,
  input  logic [63:0] mem_biu_rdata
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   drop_q, drop_d;

  logic issue_ok, grant_ifu, grant_lsu, ifu_ack, lsu_ack, rsp_vld, starve_at_max;
  logic unused_ifu_addr_lsbs;

  assign unused_ifu_addr_lsbs = ^ifu_biu_addr[2:0];

  // A new request may go out in the same cycle the previous response returns.
  assign issue_ok  = resetn & ((state_q == StIdle) | mem_biu_rvalid);
  assign grant_ifu = issue_ok & ifu_biu_req & (~lsu_biu_req | starve_at_max);
  assign grant_lsu = issue_ok & lsu_biu_req & ~grant_ifu;
  assign ifu_ack   = grant_ifu & mem_biu_ack;
  assign lsu_ack   = grant_lsu & mem_biu_ack;

  assign biu_ifu_ack = ifu_ack;
  assign biu_lsu_ack = lsu_ack;

  assign rsp_vld          = resetn & (state_q == StBusy) & mem_biu_rvalid;
  assign biu_lsu_data_vld = rsp_vld & (owner_q == OwnLsu);
  assign biu_ifu_data_vld = rsp_vld & (owner_q == OwnIfu) & ~drop_q & ~ifu_biu_cancel;
  assign biu_ifu_data     = resetn ? mem_biu_rdata : '0;
  assign biu_lsu_data     = resetn ? mem_biu_rdata : '0;

  always_comb begin
    biu_mem_req   = 1'b0;
    biu_mem_wr    = 1'b0;
    biu_mem_addr  = '0;
    biu_mem_wdata = '0;
    biu_mem_wstrb = '0;
    if (grant_ifu) begin
      biu_mem_req  = 1'b1;
      biu_mem_addr = {ifu_biu_addr[31:3], 3'b000};
    end else if (grant_lsu) begin
      biu_mem_req   = 1'b1;
      biu_mem_wr    = lsu_biu_wr;
      biu_mem_addr  = lsu_biu_addr;
      biu_mem_wdata = lsu_biu_wr ? lsu_biu_wdata : '0;
      biu_mem_wstrb = lsu_biu_wr ? lsu_biu_wstrb : '0;
    end
  end

  // A cancel coinciding with an IFU ack targets the old fetch, not the new one.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    if (ifu_ack || lsu_ack) begin
      state_d = StBusy;
      owner_d = lsu_ack ? OwnLsu : OwnIfu;
      drop_d  = 1'b0;
    end else if ((state_q == StBusy) && mem_biu_rvalid) begin
      state_d = StIdle;
    end else if ((state_q == StBusy) && (owner_q == OwnIfu) && ifu_biu_cancel) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= OwnIfu;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
    end
  end

  c7bbiu_starve_cnt #(
    .StarveMax(STARVE_MAX)
  ) u_starve_cnt (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .clr_i   (ifu_ack | ~ifu_biu_req),
    .inc_i   (lsu_ack & ifu_biu_req),
    .at_max_o(starve_at_max)
  );

endmodule

// File: doc/c7bbiu_arb.md
# c7bbiu_arb

Two-requester arbiter for the core's single 64-bit memory port. It shares the port between IFU instruction fetch (read-only) and LSU load/store traffic. It sits between the IFU/LSU request interfaces and the bus/memory port. It allows one outstanding transaction, routes each response back to its owner, drops IFU responses made stale by a pipeline flush, and prevents LSU traffic from starving fetch.

## Interface
Parameters:
- STARVE_MAX, 4: number of consecutive LSU grants allowed while IFU is waiting; after that IFU gets forced priority. Legal range 1..7.

Ports:
- clk  in  1  core clock; everything is rising-edge.
- resetn  in  1  reset, asynchronous, active-low.
- ifu_biu_req  in  1  IFU fetch request; held until acked.
- ifu_biu_addr  in  32  fetch address; bits [2:0] are ignored.
- biu_ifu_ack  out  1  IFU request accepted this cycle.
- biu_ifu_data_vld  out  1  fetch data valid.
- biu_ifu_data  out  64  fetch data.
- ifu_biu_cancel  in  1  flush pulse; stale IFU response is dropped.
- lsu_biu_req  in  1  LSU request; held until acked.
- lsu_biu_wr  in  1  1 = store, 0 = load.
- lsu_biu_addr  in  32  LSU address.
- lsu_biu_wdata  in  64  store data.
- lsu_biu_wstrb  in  8  store byte strobes.
- biu_lsu_ack  out  1  LSU request accepted this cycle.
- biu_lsu_data_vld  out  1  load data valid, or store completion.
- biu_lsu_data  out  64  load data.
- biu_mem_req  out  1  memory request.
- biu_mem_wr  out  1  write flag.
- biu_mem_addr  out  32  memory address.
- biu_mem_wdata  out  64  write data.
- biu_mem_wstrb  out  8  write strobes; 0 for reads.
- mem_biu_ack  in  1  memory accepts the request this cycle.
- mem_biu_rvalid  in  1  response for the outstanding transaction, arriving at least 1 cycle after ack.
- mem_biu_rdata  in  64  read data.

## Operation
- State machine has two states.
  - IDLE: no transaction outstanding.
  - BUSY: one transaction outstanding. Registered owner is IFU or LSU; there is also a drop flag.
- Issue is allowed when state is IDLE, or when state is BUSY and mem_biu_rvalid=1 (issue in the response cycle).
- When issue is allowed, the arbiter drives biu_mem_* from the winning requester.
  - IFU wins only if ifu_biu_req=1 and either lsu_biu_req=0 or the starve counter equals STARVE_MAX.
  - Otherwise the LSU wins.
- For an IFU issue: biu_mem_addr={ifu_biu_addr[31:3],3'b0}, wr=0, wstrb=0, wdata=0.
- Acks are combinational: biu_X_ack = granted_X & mem_biu_ack.
- On an ack:
  - state goes to BUSY, owner is set to the acked requester, and drop is cleared.
  - With no ack and no outstanding transaction, state goes to IDLE.
- Response routing is combinational:
  - biu_lsu_data_vld = BUSY & owner==LSU & rvalid.
  - biu_ifu_data_vld = BUSY & owner==IFU & rvalid & ~drop & ~ifu_biu_cancel.
  - Both data outputs pass mem_biu_rdata straight through.
- Cancel:
  - ifu_biu_cancel=1 while BUSY with owner IFU sets drop. The response is still consumed from memory but is not forwarded.
  - Cancel does not affect an IFU request acked in the same cycle. That request is the post-flush target fetch and is delivered normally.
  - Cancel has no effect while owner is LSU.
- Starve counter (3 bits):
  - Cleared on IFU ack.
  - Incremented on LSU ack when ifu_biu_req=1.
  - Saturates at STARVE_MAX.
  - Cleared when ifu_biu_req=0.
- mem_biu_rvalid while IDLE is ignored: no data_vld is asserted.
- A write is complete when rvalid arrives; the LSU sees it as a biu_lsu_data_vld pulse.

## Timing
- Reset values: state IDLE, owner IFU, drop 0, counter 0. All outputs are 0 while resetn=0.
- Request to ack takes 0 cycles when memory acks combinationally.
- Ack to data_vld takes at least 1 cycle and equals memory latency; data_vld is asserted in the same cycle as rvalid.
- Maximum throughput is one transaction per memory round trip. With issue in the response cycle there are no idle cycles between transactions.
- Reset mid-transaction discards the outstanding response. Any rvalid seen after reset is ignored because state is IDLE.

## Structure
- Shared package c7b_biu_pkg holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1;
  - owner encoding: IFU=1'b0, LSU=1'b1;
  - default STARVE_MAX.
- One natural sub-module: c7bbiu_starve_cnt, the saturating counter with clear/increment/max compare. All remaining logic stays flat.

## Test plan
- IFU only, addr 0x1c000004, memory latency 2: mem addr is 0x1c000000, ack in cycle 0, biu_ifu_data_vld in cycle 2 carrying rdata 0x0011223344556677.
- IFU and LSU request together from IDLE: LSU acked first; IFU acked in the LSU rvalid cycle; no idle cycles in between.
- LSU requests held continuously with STARVE_MAX=4 and IFU waiting: grant sequence is 4 LSU, then 1 IFU, then LSU again.
- IFU fetch acked, cancel pulsed 1 cycle later, new IFU request acked in the cancel cycle's next issue slot: first rvalid produces no data_vld; second produces data_vld.
- Cancel in the same cycle as an IFU ack: that fetch's data is delivered. Cancel in the same cycle as IFU rvalid: data is suppressed.
- LSU store, wstrb=0x0F, latency 3: mem wr=1 and wstrb=0x0F; biu_lsu_data_vld pulses at rvalid. resetn asserted while BUSY: later rvalid produces no data_vld and all outputs are 0.
